// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, DBIT data bits LSB first, optional parity, stop period.
// Define UART_TX_PARITY_EN to insert a parity bit (sense chosen by PARITY_ODD).
module uart_tx_serializer #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
  output logic            tx,
  output logic            tx_done_tick,
  output logic            busy
);

  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  // Out-of-range configurations stop elaboration rather than build a broken frame.
  if (DBIT < 5 || DBIT > 9 || SB_TICK < 16 || SB_TICK > 32 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_cfg_err
    $error("uart_tx_serializer: parameter out of range");
  end

  state_t          state;
  logic [4:0]      s;
  logic [NW-1:0]   n;
  logic [DBIT-1:0] b;
`ifdef UART_TX_PARITY_EN
  logic            p;
`endif

  // The done strobe must fall in the last stop cycle itself so the FIFO pops on the
  // same edge the FSM returns to IDLE, leaving exactly one idle-high clk between frames.
  assign tx_done_tick = (state == STOP) && s_tick && (s == 5'(SB_TICK - 1));
  assign busy         = (state != IDLE);

  // NOTE: every register here is updated with non-blocking assignments so that all
  // branches see the pre-edge values of s, n and b regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      s     <= '0;
      n     <= '0;
      b     <= '0;
      tx    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      p     <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (tx_start) begin
            b     <= din;
            s     <= '0;
            tx    <= 1'b0;
            state <= START;
          end
        end

        START: begin
          if (s_tick) begin
            if (s == 5'd15) begin
              s     <= '0;
              n     <= '0;
              tx    <= b[0];
`ifdef UART_TX_PARITY_EN
              p     <= 1'b0;
`endif
              state <= DATA;
            end else begin
              s <= s + 5'd1;
            end
          end
        end

        DATA: begin
          if (s_tick) begin
            if (s == 5'd15) begin
              s <= '0;
              b <= b >> 1;
`ifdef UART_TX_PARITY_EN
              p <= p ^ b[0];
`endif
              if (n == NW'(DBIT - 1)) begin
`ifdef UART_TX_PARITY_EN
                tx    <= p ^ b[0] ^ PARITY_ODD[0];
                state <= PARITY;
`else
                tx    <= 1'b1;
                state <= STOP;
`endif
              end else begin
                n  <= n + 1'b1;
                tx <= b[1];
              end
            end else begin
              s <= s + 5'd1;
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (s_tick) begin
            if (s == 5'd15) begin
              s     <= '0;
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              s <= s + 5'd1;
            end
          end
        end
`endif

        STOP: begin
          if (s_tick) begin
            if (s == 5'(SB_TICK - 1)) begin
              s     <= '0;
              state <= IDLE;
            end else begin
              s <= s + 5'd1;
            end
          end
        end

        default: begin
          s     <= '0;
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
